// File: rtl/min_pkg.sv
// Shared definitions for the minimum pipeline and its window tracker:
// default width, unsigned two-input minimum, and parameter legality check.
package min_pkg;

  localparam int DW_DEF = 8;
  localparam int MAXW   = 32;

  // Ties return a, so a running value stays put when an equal sample arrives.
  function automatic logic [MAXW-1:0] min_u(input logic [MAXW-1:0] a,
                                            input logic [MAXW-1:0] b);
    return (b < a) ? b : a;
  endfunction

  function automatic bit cfg_ok(input int win, input int depth);
    return (win >= 1) && (win <= 255) && (depth >= 2) &&
           ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/min_res_fifo.sv
// Synchronous result FIFO with occupancy count; head reads as 0 when empty.
module min_res_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            wr_data,
  output logic [DW-1:0]            rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/min_window_track.sv
// Reduces every WIN valid samples to their minimum and queues the results
// toward a valid/ready consumer, flagging results lost to a full queue.
module min_window_track
  import min_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int WIN   = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DW-1:0]            in_data,
  input  logic                     clear,
  output logic                     out_valid,
  output logic [DW-1:0]            out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf
);

  localparam int CW = (WIN > 1) ? $clog2(WIN) : 1;

  if (!cfg_ok(WIN, DEPTH)) begin : g_cfg_err
    $error("min_window_track: illegal WIN/DEPTH");
  end

  logic [CW-1:0] cnt;
  logic [DW-1:0] run_min;
  logic [DW-1:0] sample_min;
  logic [DW-1:0] win_res;
  logic          accept;
  logic          last;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          drop;

  assign accept     = in_valid && !clear;
  assign last       = (cnt == CW'(WIN - 1));
  assign sample_min = DW'(min_u(MAXW'(run_min), MAXW'(in_data)));
  assign win_res    = (WIN == 1) ? in_data : sample_min;
  assign push       = accept && last;
  assign pop        = out_valid && out_ready;
  assign drop       = push && full && !pop;
  assign out_valid  = !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      run_min <= '0;
      ovf     <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (in_valid) begin
        cnt     <= last ? '0 : cnt + CW'(1);
        run_min <= (cnt == '0) ? in_data : sample_min;
      end
      if (drop) ovf <= 1'b1;
    end
  end

  min_res_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (win_res),
    .rd_data (out_data),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

endmodule
